// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared FSM state encoding and default operand width for the Booth multiplier
package booth_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_Q,
        EVAL,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/booth_datapath.sv
// rtl/booth_datapath.sv - Booth register/arithmetic path: A (with sign guard), Q, M, qm1, iteration count
module booth_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ldM,
    input  logic             clrA,
    input  logic             clrff,
    input  logic             ldcnt,
    input  logic             ldQ,
    input  logic             ldA,
    input  logic             addsub,
    input  logic             sftA,
    input  logic             sftQ,
    input  logic             decr,
    output logic             q0,
    output logic             qm1,
    output logic             eqz,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] q
);

    localparam int CW = $clog2(WIDTH + 1);

    // One extra guard bit on A keeps A-M exact when M is the most negative value.
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] q_reg;
    logic             qm1_reg;
    logic [CW-1:0]    count;

    assign m_ext = {m_reg[WIDTH-1], m_reg};
    assign sum   = addsub ? (a_ext - m_ext) : (a_ext + m_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_ext   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            qm1_reg <= 1'b0;
            count   <= '0;
        end else begin
            if (ldM)
                m_reg <= data_in;

            if (clrA)
                a_ext <= '0;
            else if (ldA)
                a_ext <= sum;
            else if (sftA)
                a_ext <= {a_ext[WIDTH], a_ext[WIDTH:1]};

            if (ldQ)
                q_reg <= data_in;
            else if (sftQ)
                q_reg <= {a_ext[0], q_reg[WIDTH-1:1]};

            if (clrff)
                qm1_reg <= 1'b0;
            else if (sftQ)
                qm1_reg <= q_reg[0];

            if (ldcnt)
                count <= CW'(WIDTH);
            else if (decr)
                count <= count - CW'(1);
        end
    end

    // Flags the final iteration: this SHIFT's decrement brings the count to zero.
    assign eqz = (count == CW'(1));
    assign q0  = q_reg[0];
    assign qm1 = qm1_reg;
    assign a   = a_ext[WIDTH-1:0];
    assign q   = q_reg;

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - radix-2 Booth sequential signed multiplier: FSM driving booth_datapath
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             done,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Q
);

    state_t state;

    logic ldM, clrA, clrff, ldcnt, ldQ, ldA, addsub, sftA, sftQ, decr;
    logic q0, qm1, eqz;

    always_comb begin
        ldM    = 1'b0;
        clrA   = 1'b0;
        clrff  = 1'b0;
        ldcnt  = 1'b0;
        ldQ    = 1'b0;
        ldA    = 1'b0;
        addsub = 1'b0;
        sftA   = 1'b0;
        sftQ   = 1'b0;
        decr   = 1'b0;
        case (state)
            LOAD_M: begin
                ldM   = 1'b1;
                clrA  = 1'b1;
                clrff = 1'b1;
                ldcnt = 1'b1;
            end
            LOAD_Q: ldQ = 1'b1;
            EVAL: begin
                // 01 adds M, 10 subtracts M, 00/11 leave A alone.
                ldA    = q0 ^ qm1;
                addsub = q0 & ~qm1;
            end
            SHIFT: begin
                sftA = 1'b1;
                sftQ = 1'b1;
                decr = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE:   if (start) state <= LOAD_M;
                LOAD_M: state <= LOAD_Q;
                LOAD_Q: state <= EVAL;
                EVAL:   state <= SHIFT;
                SHIFT: begin
                    if (eqz) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= EVAL;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    booth_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .ldM     (ldM),
        .clrA    (clrA),
        .clrff   (clrff),
        .ldcnt   (ldcnt),
        .ldQ     (ldQ),
        .ldA     (ldA),
        .addsub  (addsub),
        .sftA    (sftA),
        .sftQ    (sftQ),
        .decr    (decr),
        .q0      (q0),
        .qm1     (qm1),
        .eqz     (eqz),
        .a       (A),
        .q       (Q)
    );

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - self-checking bench for booth_multiplier against an integer product model
module tb_booth_multiplier;

    localparam int W   = 16;
    localparam int LAT = 2 + 2 * W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic         done;
    logic [W-1:0] A;
    logic [W-1:0] Q;

    int n_checks = 0;
    int n_fail   = 0;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .done    (done),
        .A       (A),
        .Q       (Q)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_prod(input logic signed [W-1:0] m, input logic signed [W-1:0] q);
        longint p;
        p = longint'(m) * longint'(q);
        return p[2*W-1:0];
    endfunction

    // Drives start and both operands; returns just after the edge that loads Q (2 cycles into the operation).
    task automatic begin_mul(input logic [W-1:0] m, input logic [W-1:0] q, input logic keep_start);
        @(negedge clk);
        start   = 1'b1;
        data_in = W'($urandom);
        @(posedge clk); #1;
        start   = keep_start;
        data_in = m;
        @(posedge clk); #1;
        data_in = q;
        @(posedge clk); #1;
        data_in = W'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 2;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                                 input logic [W-1:0] exp_a, input logic [W-1:0] exp_q);
        int lat;
        begin_mul(m, q, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, LAT);
        end
        n_checks++;
        if ({A, Q} !== {exp_a, exp_q}) begin
            n_fail++;
            $display("FAIL %s product: got A=%h Q=%h, expected A=%h Q=%h", name, A, Q, exp_a, exp_q);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_fall: got done=%b, expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; data_in = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({done, A, Q} !== {1'b0, 16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_state: got done=%b A=%h Q=%h, expected done=0 A=0000 Q=0000", done, A, Q);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({done, A, Q} !== {1'b0, 16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL idle_hold: got done=%b A=%h Q=%h, expected done=0 A=0000 Q=0000", done, A, Q);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] tm [6] = '{16'd20, 16'd7, 16'd0,    16'h8000, 16'h8000, 16'h7FFF};
        logic [W-1:0] tq [6] = '{16'hFFE2, 16'd5, 16'hFFFF, 16'h8000, 16'h0001, 16'h8000};
        logic [W-1:0] ea [6] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h4000, 16'hFFFF, 16'hC000};
        logic [W-1:0] eq [6] = '{16'hFDA8, 16'h0023, 16'h0000, 16'h0000, 16'h8000, 16'h8000};
        for (int i = 0; i < 6; i++)
            run_and_check($sformatf("directed%0d", i), tm[i], tq[i], ea[i], eq[i]);
    endtask

    task automatic test_random();
        logic [W-1:0]   m, q;
        logic [2*W-1:0] p;
        for (int i = 0; i < 20; i++) begin
            m = W'($urandom);
            q = W'($urandom);
            if (i == 0) m = 16'h8000;
            if (i == 1) q = 16'h7FFF;
            p = ref_prod(m, q);
            run_and_check($sformatf("random%0d", i), m, q, p[2*W-1:W], p[W-1:0]);
        end
    endtask

    task automatic test_rst_abort();
        begin_mul(16'd100, 16'hFFB3, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({done, A, Q} !== {1'b0, 16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL abort_clear: got done=%b A=%h Q=%h, expected done=0 A=0000 Q=0000", done, A, Q);
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got done=%b, expected 0", done);
        end
        run_and_check("after_abort", 16'd3, 16'hFFFC, 16'hFFFF, 16'hFFF4);
    endtask

    task automatic test_hold_start();
        int             lat;
        logic [2*W-1:0] p;
        logic [2*W-1:0] p2;
        p = ref_prod(16'hFF9C, 16'h0131);
        begin_mul(16'hFF9C, 16'h0131, 1'b1);
        wait_done(lat);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL hold_latency: got %0d cycles, expected %0d", lat, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({done, A, Q} !== {1'b1, p}) begin
                n_fail++;
                $display("FAIL hold_stable%0d: got done=%b A=%h Q=%h, expected done=1 A=%h Q=%h",
                         i, done, A, Q, p[2*W-1:W], p[W-1:0]);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({done, A, Q} !== {1'b0, p}) begin
            n_fail++;
            $display("FAIL hold_release: got done=%b A=%h Q=%h, expected done=0 A=%h Q=%h",
                     done, A, Q, p[2*W-1:W], p[W-1:0]);
        end
        p2 = ref_prod(16'h0045, 16'hFFF9);
        run_and_check("restart", 16'h0045, 16'hFFF9, p2[2*W-1:W], p2[W-1:0]);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   m, q;
        logic [2*W-1:0] p;
        for (int i = 0; i < 4; i++) begin
            m = W'($urandom_range(0, 255)) - 16'd128;
            q = W'($urandom);
            p = ref_prod(m, q);
            run_and_check($sformatf("b2b%0d", i), m, q, p[2*W-1:W], p[W-1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_rst_abort();
        test_hold_start();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
